// File: rtl/rns_pkg.sv
// ============================================================================
//  Module      : rns_pkg
//  Description : Shared constants for the {2^25+1, 2^25, 2^25-1} residue
//                number system forward converter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rns_pkg;

    // Word size of the moduli set
    localparam int C_N  = 25;

    // Channel and operand widths
    localparam int C_W1 = 26;   // residue mod 2^25+1, range 0..2^25
    localparam int C_W2 = 25;   // residue mod 2^25
    localparam int C_W3 = 25;   // residue mod 2^25-1
    localparam int C_WX = 75;   // binary operand

    // Moduli that need explicit constants (m2 is a plain bit slice)
    localparam logic [C_W1-1:0] C_M1 = 26'h200_0001;
    localparam logic [C_W3-1:0] C_M3 = 25'h1FF_FFFF;

    // M = 2^75 - 2^25: X >= M exactly when the top 50 bits are all ones
    localparam logic [C_WX-C_N-1:0] C_M_TOP_MASK = 50'h3_FFFF_FFFF_FFFF;

    // Stage-1 payload carried between the two pipeline stages
    typedef struct packed {
        logic            rng;   // operand not uniquely representable
        logic [C_N:0]    s02;   // B0 + B2, full 26-bit sum
        logic [C_N-1:0]  t3;    // (B0 + B2) mod m3
        logic [C_N-1:0]  b0;    // low word, becomes x2 directly
        logic [C_N-1:0]  b1;    // middle word
    } s1_t;

endpackage : rns_pkg

`default_nettype wire

// File: rtl/add_mod_2n_m1.sv
// ============================================================================
//  Module      : add_mod_2n_m1
//  Description : 25-bit modulo (2^25-1) adder using end-around carry. The
//                all-ones pattern (the second encoding of zero) is folded to
//                0 so the result is always canonical, range 0..2^25-2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_mod_2n_m1
    import rns_pkg::*;
(
    input  logic [C_N-1:0] i_a,
    input  logic [C_N-1:0] i_b,
    output logic [C_N-1:0] o_sum
);

    logic [C_N:0]   w_raw;
    logic [C_N-1:0] w_eac;

    // Plain sum, then wrap the carry back into bit 0. When the carry is set
    // the low word is at most 2^25-2, so adding it back cannot overflow.
    always_comb begin
        w_raw = {1'b0, i_a} + {1'b0, i_b};
        w_eac = w_raw[C_N-1:0] + {{(C_N-1){1'b0}}, w_raw[C_N]};
        o_sum = (&w_eac) ? '0 : w_eac;
    end

endmodule : add_mod_2n_m1

`default_nettype wire

// File: rtl/forward_converter_33554433_33554432_33554431.sv
// ============================================================================
//  Module      : forward_converter_33554433_33554432_33554431
//  Description : Binary to RNS forward converter for the moduli set
//                {2^25+1, 2^25, 2^25-1}. Two-stage valid/ready pipeline:
//                stage 1 splits X into three 25-bit words and forms partial
//                sums, stage 2 registers the final residues.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module forward_converter_33554433_33554432_33554431
    import rns_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [C_WX-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [C_W1-1:0] x1,
    output logic [C_W2-1:0] x2,
    output logic [C_W3-1:0] x3,
    output logic            out_range,
    output logic            out_valid,
    input  logic            out_ready
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic  r_v1;
    logic  r_v2;
    logic  w_adv2;
    logic  w_acc;
    s1_t   r_s1;
    s1_t   w_s1;

    // Stage 2 can take a new word when it is empty or being drained;
    // stage 1 can take one when it is empty or moving into stage 2.
    assign w_adv2    = !r_v2 || out_ready;
    assign in_ready  = !r_v1 || w_adv2;
    assign w_acc     = in_valid && in_ready;
    assign out_valid = r_v2;

    // ------------------------------------------------------------------
    // Stage 1 datapath
    // ------------------------------------------------------------------
    logic [C_N-1:0] w_b0;
    logic [C_N-1:0] w_b1;
    logic [C_N-1:0] w_b2;
    logic [C_N-1:0] w_t3;

    assign w_b0 = in_data[C_N-1:0];
    assign w_b1 = in_data[2*C_N-1:C_N];
    assign w_b2 = in_data[3*C_N-1:2*C_N];

    // B0 + B2 reduced mod m3; B1 is folded in during stage 2
    add_mod_2n_m1 u_add_s1 (
        .i_a   (w_b0),
        .i_b   (w_b2),
        .o_sum (w_t3)
    );

    // Assemble the stage-1 payload from the split operand
    always_comb begin
        w_s1     = '0;
        w_s1.rng = (in_data[C_WX-1:C_N] == C_M_TOP_MASK);
        w_s1.s02 = {1'b0, w_b0} + {1'b0, w_b2};
        w_s1.t3  = w_t3;
        w_s1.b0  = w_b0;
        w_s1.b1  = w_b1;
    end

    // Stage 1 register: load on accept, hold while stage 2 is blocked
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else begin
            if (w_acc) begin
                r_s1 <= w_s1;
            end
            if (in_ready) begin
                r_v1 <= in_valid;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 datapath
    // ------------------------------------------------------------------
    logic [C_N-1:0]  w_x3;
    logic [C_W1:0]   w_d;      // 27-bit signed B0 + B2 - B1
    logic [C_W1-1:0] w_x1;

    // (B0 + B2) + B1 mod m3
    add_mod_2n_m1 u_add_s2 (
        .i_a   (r_s1.t3),
        .i_b   (r_s1.b1),
        .o_sum (w_x3)
    );

    // B0 - B1 + B2 lies in [-(2^25-1), 2^26-2]; one correction step in
    // either direction lands it in 0..2^25.
    always_comb begin
        w_d  = {1'b0, r_s1.s02} - {2'b00, r_s1.b1};
        w_x1 = w_d[C_W1-1:0];
        if (w_d[C_W1]) begin
            w_x1 = w_d[C_W1-1:0] + C_M1;
        end else if (w_d[C_W1-1:0] >= C_M1) begin
            w_x1 = w_d[C_W1-1:0] - C_M1;
        end
    end

    // Stage 2 register: outputs change only when stage 2 advances
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2      <= 1'b0;
            x1        <= '0;
            x2        <= '0;
            x3        <= '0;
            out_range <= 1'b0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                x1        <= w_x1;
                x2        <= r_s1.b0;
                x3        <= w_x3;
                out_range <= r_s1.rng;
            end
        end
    end

endmodule : forward_converter_33554433_33554432_33554431

`default_nettype wire

// File: tb/tb_forward_converter_33554433_33554432_33554431.sv
// ============================================================================
//  Module      : tb_forward_converter_33554433_33554432_33554431
//  Description : Scoreboard bench for the RNS forward converter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_forward_converter_33554433_33554432_33554431;

    logic        clk = 1'b0;
    logic        rst;
    logic [74:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] x1;
    logic [24:0] x2;
    logic [24:0] x3;
    logic        out_range;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    forward_converter_33554433_33554432_33554431 u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .out_range (out_range),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct packed {
        logic        rng;
        logic [25:0] r1;
        logic [24:0] r2;
        logic [24:0] r3;
    } res_t;

    res_t q_exp[$];
    int   q_cyc[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic lat_chk  = 1'b0;
    logic hold_chk = 1'b0;
    res_t held;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Golden model straight from the arithmetic definition
    function automatic res_t model(input logic [74:0] x);
        logic [75:0] xx;
        logic [75:0] mm;
        res_t r;
        xx    = {1'b0, x};
        mm    = (76'd1 << 75) - (76'd1 << 25);
        r.r1  = 26'(xx % 76'd33554433);
        r.r2  = 25'(xx % 76'd33554432);
        r.r3  = 25'(xx % 76'd33554431);
        r.rng = (xx >= mm);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        res_t e;
        int   c;
        if (rst) begin
            q_exp.delete();
            q_cyc.delete();
            hold_chk = 1'b0;
        end else begin
            check("in_ready", 128'(in_ready), 128'((q_exp.size() < 2) || out_ready));
            if (hold_chk) begin
                check("stall_hold", 128'({out_valid, out_range, x1, x2, x3}),
                      128'({1'b1, held}));
            end
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    check("spurious_out", 128'(1), 128'(0));
                end else begin
                    e = q_exp.pop_front();
                    c = q_cyc.pop_front();
                    check("x1", 128'(x1), 128'(e.r1));
                    check("x2", 128'(x2), 128'(e.r2));
                    check("x3", 128'(x3), 128'(e.r3));
                    check("out_range", 128'(out_range), 128'(e.rng));
                    if (lat_chk) check("latency", 128'(cyc - c), 128'(2));
                end
            end
            if (in_valid && in_ready) begin
                q_exp.push_back(model(in_data));
                q_cyc.push_back(cyc);
            end
            hold_chk = out_valid && !out_ready;
            held     = '{rng: out_range, r1: x1, r2: x2, r3: x3};
        end
    end

    // Present one word and wait (bounded) for it to be accepted
    task automatic send(input logic [74:0] x);
        logic acc;
        int   guard;
        in_valid = 1'b1;
        in_data  = x;
        guard    = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) check("accept_timeout", 128'(0), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q_exp.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain", 128'(q_exp.size()), 128'(0));
    endtask

    logic [74:0] dir_vec [7];

    initial begin
        logic [74:0] r;
        dir_vec[0] = 75'd0;
        dir_vec[1] = 75'd1;
        dir_vec[2] = 75'd1 << 25;
        dir_vec[3] = (75'd1 << 25) - 75'd1;
        dir_vec[4] = 75'd1 << 50;
        dir_vec[5] = {{50{1'b1}}, 25'd0} - 75'd1;
        dir_vec[6] = {75{1'b1}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_outputs", 128'({out_range, x1, x2, x3}), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;

        // Directed corner values, back to back, full throughput
        lat_chk = 1'b1;
        foreach (dir_vec[i]) send(dir_vec[i]);
        drain();
        lat_chk = 1'b0;

        // Ten-word stream with downstream stalled for cycles 3-7
        fork
            begin
                for (int i = 0; i < 10; i++) send(75'({$urandom, $urandom, $urandom}));
            end
            begin
                for (int k = 0; k < 14; k++) begin
                    out_ready = !(k >= 3 && k <= 7);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random gaps and back-pressure
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    r = 75'({$urandom, $urandom, $urandom});
                    if ($urandom_range(0, 7) == 0) r[74:25] = '1;
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(r);
                end
            end
            begin
                for (int k = 0; k < 6000; k++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join_any
        out_ready = 1'b1;
        drain();
        disable fork;
        out_ready = 1'b1;

        // Reset with two words in flight
        out_ready = 1'b0;
        send(75'h123_4567_89AB_CDEF_0123);
        send(75'h7FF_0000_1111_2222_3333);
        @(negedge clk);
        check("full_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 75'd5;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst2_out_valid", 128'(out_valid), 128'(0));
        check("rst2_outputs", 128'({out_range, x1, x2, x3}), 128'(0));
        check("rst2_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("no_stale", 128'(out_valid), 128'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_forward_converter_33554433_33554432_33554431

`default_nettype wire
